// File: rtl/mcu_pkg.sv
// Shared MCU datapath definitions: register address width, no-op destination and
// the stall-controller state encoding.
package mcu_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam logic [REG_ADDR_W-1:0] NOP_DA = 3'b000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } stall_state_e;

endpackage

// File: rtl/pipe_ctrl_reg.sv
// DA/RW pipeline register with synchronous clear and bubble insertion; used once per stage.
module pipe_ctrl_reg
  import mcu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  bubble_i,
  input  logic [REG_ADDR_W-1:0] da_i,
  input  logic                  rw_i,
  output logic [REG_ADDR_W-1:0] da_o,
  output logic                  rw_o
);

  logic [REG_ADDR_W-1:0] da_d, da_q;
  logic                  rw_d, rw_q;

  always_comb begin
    da_d = da_i;
    rw_d = rw_i;
    if (clr_i || bubble_i) begin
      da_d = NOP_DA;
      rw_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    da_q <= da_d;
    rw_q <= rw_d;
  end

  assign da_o = da_q;
  assign rw_o = rw_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard-driven stall/flush control for the decode stage, carrying the EX/WB control
// fields and tracking stall statistics.
module pipeline_stall_ctrl
  import mcu_pkg::*;
#(
  parameter int unsigned MAX_STALL = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  DHS,
  input  logic                  BHS,
  input  logic [REG_ADDR_W-1:0] id_DA,
  input  logic                  id_RW,
  output logic                  pc_en,
  output logic                  ir_en,
  output logic                  ir_flush,
  output logic                  bubble,
  output logic [REG_ADDR_W-1:0] ex_DA,
  output logic                  ex_RW,
  output logic [REG_ADDR_W-1:0] wb_DA,
  output logic                  wb_RW,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  stall_err
);

  localparam int unsigned RunW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_STALL);

  logic flush, hazard;
  stall_state_e state_d, state_q;
  logic [RunW-1:0]  run_len_d, run_len_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic             stall_err_d, stall_err_q;

  // A taken branch squashes the stalled instruction, so flush masks the data hazard.
  assign flush  = ~BHS;
  assign hazard = ~DHS & ~flush;

  assign bubble   = reset_n & (hazard | flush);
  assign pc_en    = reset_n & ~hazard;
  assign ir_en    = reset_n & ~hazard;
  assign ir_flush = reset_n & flush;

  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    stall_cnt_d = stall_cnt_q;
    stall_err_d = stall_err_q;

    unique case (state_q)
      ST_RUN: begin
        if (hazard) begin
          state_d   = ST_STALL;
          run_len_d = RunW'(1);
        end else begin
          run_len_d = '0;
        end
      end
      ST_STALL: begin
        if (hazard) begin
          if (run_len_q == RunMax) begin
            stall_err_d = 1'b1;
          end else begin
            run_len_d = run_len_q + RunW'(1);
          end
        end else begin
          state_d   = ST_RUN;
          run_len_d = '0;
        end
      end
      default: begin
        state_d   = ST_RUN;
        run_len_d = '0;
      end
    endcase

    if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      run_len_q   <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  pipe_ctrl_reg u_ex_reg (
    .clk_i    (clk),
    .clr_i    (~reset_n),
    .bubble_i (bubble),
    .da_i     (id_DA),
    .rw_i     (id_RW),
    .da_o     (ex_DA),
    .rw_o     (ex_RW)
  );

  pipe_ctrl_reg u_wb_reg (
    .clk_i    (clk),
    .clr_i    (~reset_n),
    .bubble_i (1'b0),
    .da_i     (ex_DA),
    .rw_i     (ex_RW),
    .da_o     (wb_DA),
    .rw_o     (wb_RW)
  );

  assign stall_cnt = stall_cnt_q;
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed vector bench for pipeline_stall_ctrl; a second CNT_W=2 instance shares the
// stimulus to exercise counter saturation.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       DHS = 1'b1;
  logic       BHS = 1'b1;
  logic [2:0] id_DA = 3'd0;
  logic       id_RW = 1'b0;

  logic       pc_en, ir_en, ir_flush, bubble, ex_RW, wb_RW, stall_err;
  logic [2:0] ex_DA, wb_DA;
  logic [7:0] stall_cnt;

  logic       s_pc_en, s_ir_en, s_ir_flush, s_bubble, s_ex_RW, s_wb_RW, s_stall_err;
  logic [2:0] s_ex_DA, s_wb_DA;
  logic [1:0] s_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MAX_STALL(2), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .DHS(DHS), .BHS(BHS), .id_DA(id_DA), .id_RW(id_RW),
    .pc_en(pc_en), .ir_en(ir_en), .ir_flush(ir_flush), .bubble(bubble),
    .ex_DA(ex_DA), .ex_RW(ex_RW), .wb_DA(wb_DA), .wb_RW(wb_RW),
    .stall_cnt(stall_cnt), .stall_err(stall_err)
  );

  pipeline_stall_ctrl #(.MAX_STALL(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .DHS(DHS), .BHS(BHS), .id_DA(id_DA), .id_RW(id_RW),
    .pc_en(s_pc_en), .ir_en(s_ir_en), .ir_flush(s_ir_flush), .bubble(s_bubble),
    .ex_DA(s_ex_DA), .ex_RW(s_ex_RW), .wb_DA(s_wb_DA), .wb_RW(s_wb_RW),
    .stall_cnt(s_stall_cnt), .stall_err(s_stall_err)
  );

  typedef struct {
    logic       rst_n, dhs, bhs;
    logic [2:0] da;
    logic       rw;
    logic       pc, ir, fl, bub;
    logic [2:0] exda;
    logic       exrw;
    logic [2:0] wbda;
    logic       wbrw;
    logic [7:0] cnt;
    logic       err, st;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    // rst dhs bhs da rw | pc ir fl bub | exda exrw wbda wbrw cnt err state
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                 3'd0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                 3'd0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                 3'd5, 1'b1, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                 3'd3, 1'b0, 3'd5, 1'b1, 8'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                 3'd0, 1'b0, 3'd3, 1'b0, 8'd1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                 3'd0, 1'b0, 3'd0, 1'b0, 8'd2, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                 3'd6, 1'b1, 3'd0, 1'b0, 8'd2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 3'd0, 1'b0, 3'd6, 1'b1, 8'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 3'd0, 1'b0, 3'd0, 1'b0, 8'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                 3'd4, 1'b1, 3'd0, 1'b0, 8'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                 3'd0, 1'b0, 3'd4, 1'b1, 8'd3, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                 3'd0, 1'b0, 3'd0, 1'b0, 8'd4, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                 3'd0, 1'b0, 3'd0, 1'b0, 8'd5, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                 3'd0, 1'b0, 3'd0, 1'b0, 8'd6, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                 3'd1, 1'b1, 3'd0, 1'b0, 8'd6, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                 3'd2, 1'b0, 3'd1, 1'b1, 8'd6, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                 3'd0, 1'b0, 3'd2, 1'b0, 8'd7, 1'b1, 1'b1};
    // Reset lands in the second stall cycle.
    vecs[17] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                 3'd0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      reset_n = vecs[i].rst_n;
      DHS     = vecs[i].dhs;
      BHS     = vecs[i].bhs;
      id_DA   = vecs[i].da;
      id_RW   = vecs[i].rw;
      #1;
      chk("pc_en", i, 32'(pc_en), 32'(vecs[i].pc));
      chk("ir_en", i, 32'(ir_en), 32'(vecs[i].ir));
      chk("ir_flush", i, 32'(ir_flush), 32'(vecs[i].fl));
      chk("bubble", i, 32'(bubble), 32'(vecs[i].bub));
      @(posedge clk);
      #1;
      chk("ex_DA", i, 32'(ex_DA), 32'(vecs[i].exda));
      chk("ex_RW", i, 32'(ex_RW), 32'(vecs[i].exrw));
      chk("wb_DA", i, 32'(wb_DA), 32'(vecs[i].wbda));
      chk("wb_RW", i, 32'(wb_RW), 32'(vecs[i].wbrw));
      chk("stall_cnt", i, 32'(stall_cnt), 32'(vecs[i].cnt));
      chk("stall_err", i, 32'(stall_err), 32'(vecs[i].err));
      chk("state", i, 32'(dut.state_q), 32'(vecs[i].st));
      chk("sat_cnt", i, 32'(s_stall_cnt), (vecs[i].cnt > 8'd3) ? 32'd3 : 32'(vecs[i].cnt));
    end

    // Run length restarts cleanly after the mid-stall reset.
    chk("run_len_after_reset", 99, 32'(dut.run_len_q), 32'd0);

    // Fresh saturation run: five hazard cycles from reset saturate the 2-bit counter.
    @(negedge clk);
    reset_n = 1'b1;
    DHS     = 1'b0;
    BHS     = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk("sat_run", 100 + k, 32'(s_stall_cnt), (k > 3) ? 32'd3 : 32'(k));
      chk("wide_run", 100 + k, 32'(stall_cnt), 32'(k));
    end
    chk("sat_err", 106, 32'(s_stall_err), 32'd1);

    // Sticky error survives hazard removal and clears only through reset.
    @(negedge clk);
    DHS = 1'b1;
    @(posedge clk);
    #1;
    chk("err_sticky", 107, 32'(stall_err), 32'd1);
    chk("state_run", 107, 32'(dut.state_q), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("err_cleared", 108, 32'(stall_err), 32'd0);
    chk("cnt_cleared", 108, 32'(stall_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
